// File: rtl/tl_intersection_model.sv
// Intersection model: four lane queues fed by arrival pulses and drained at a fixed pace while
// the light permits. Optional conflict checker is built when TL_CONFLICT_CHK_EN is defined.
module tl_intersection_model #(
  parameter int QW         = 4,
  parameter int DEP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  input  logic [3:0]    arr,
  output logic          Ta,
  output logic          Tal,
  output logic          Tb,
  output logic          Tbl,
  output logic [QW-1:0] qa,
  output logic [QW-1:0] qal,
  output logic [QW-1:0] qb,
  output logic [QW-1:0] qbl,
  output logic [3:0]    dep,
  output logic          ovf,
  output logic          conflict_err
);

  localparam int PW = $clog2(DEP_CYCLES) + 1;
  localparam logic [1:0]    L_GREEN   = 2'b00;
  localparam logic [1:0]    L_RED     = 2'b10;
  localparam logic [1:0]    L_LEFT    = 2'b11;
  localparam logic [PW-1:0] PACE_LAST = PW'(DEP_CYCLES - 1);
  localparam logic [QW-1:0] Q_FULL    = {QW{1'b1}};

  // lane index order matches arr/dep bits: 0=a, 1=al, 2=b, 3=bl
  logic [QW-1:0] q_q    [4];
  logic [QW-1:0] q_d    [4];
  logic [PW-1:0] pace_q [4];
  logic [PW-1:0] pace_d [4];
  logic [3:0]    dep_q, dep_d;
  logic [3:0]    permit, go;
  logic          ovf_q, ovf_d;

  always_comb begin
    permit = {Lb == L_LEFT, Lb == L_GREEN, La == L_LEFT, La == L_GREEN};
    ovf_d  = ovf_q;
    go     = '0;
    for (int i = 0; i < 4; i++) begin
      q_d[i]    = q_q[i];
      pace_d[i] = '0;
      if (permit[i] && (q_q[i] != '0)) begin
        if (pace_q[i] == PACE_LAST) go[i] = 1'b1;
        else                        pace_d[i] = pace_q[i] + PW'(1);
      end
      // simultaneous arrival and departure cancel out, so a full queue never overflows then
      if (arr[i] && !go[i]) begin
        if (q_q[i] == Q_FULL) ovf_d = 1'b1;
        else                  q_d[i] = q_q[i] + QW'(1);
      end else if (!arr[i] && go[i]) begin
        q_d[i] = q_q[i] - QW'(1);
      end
    end
    dep_d = go;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        q_q[i]    <= '0;
        pace_q[i] <= '0;
      end
      dep_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        q_q[i]    <= q_d[i];
        pace_q[i] <= pace_d[i];
      end
      dep_q <= dep_d;
      ovf_q <= ovf_d;
    end
  end

`ifdef TL_CONFLICT_CHK_EN
  logic conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q | ((La != L_RED) && (Lb != L_RED));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) conflict_q <= 1'b0;
    else          conflict_q <= conflict_d;
  end

  assign conflict_err = conflict_q;
`else
  assign conflict_err = 1'b0;
`endif

  assign qa  = q_q[0];
  assign qal = q_q[1];
  assign qb  = q_q[2];
  assign qbl = q_q[3];
  assign Ta  = (q_q[0] != '0);
  assign Tal = (q_q[1] != '0);
  assign Tb  = (q_q[2] != '0);
  assign Tbl = (q_q[3] != '0);
  assign dep = dep_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_tl_intersection_model.sv
// Directed bench for tl_intersection_model with default parameters (QW=4, DEP_CYCLES=2).
// Expected conflict_err follows TL_CONFLICT_CHK_EN.
module tb_tl_intersection_model;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [1:0] LEFT   = 2'b11;

`ifdef TL_CONFLICT_CHK_EN
  localparam logic EXP_CONFLICT = 1'b1;
`else
  localparam logic EXP_CONFLICT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] La, Lb;
  logic [3:0] arr;
  logic       Ta, Tal, Tb, Tbl;
  logic [3:0] qa, qal, qb, qbl;
  logic [3:0] dep;
  logic       ovf, conflict_err;

  int errors = 0;
  int checks = 0;

  tl_intersection_model dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .La           (La),
    .Lb           (Lb),
    .arr          (arr),
    .Ta           (Ta),
    .Tal          (Tal),
    .Tb           (Tb),
    .Tbl          (Tbl),
    .qa           (qa),
    .qal          (qal),
    .qb           (qb),
    .qbl          (qbl),
    .dep          (dep),
    .ovf          (ovf),
    .conflict_err (conflict_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    La      = GREEN;
    Lb      = GREEN;
    arr     = 4'hF;

    // 1: reset dominates arrivals
    repeat (3) tick();
    chk("rst_qa", 32'(qa), 0);
    chk("rst_qal", 32'(qal), 0);
    chk("rst_qb", 32'(qb), 0);
    chk("rst_qbl", 32'(qbl), 0);
    chk("rst_dep", 32'(dep), 0);
    chk("rst_sens", 32'({Ta, Tal, Tb, Tbl}), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_conf", 32'(conflict_err), 0);

    // 2: three arrivals on lane a under RED
    reset_n = 1'b1;
    La      = RED;
    Lb      = RED;
    for (int k = 1; k <= 3; k++) begin
      arr = 4'b0001;
      tick();
      chk("fill_qa", 32'(qa), 32'(k));
      chk("fill_dep", 32'(dep), 0);
      chk("fill_Ta", 32'(Ta), 1);
    end
    arr = 4'b0000;

    // 3: GREEN drains lane a at one vehicle per 2 cycles
    La = GREEN;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("drain_dep", 32'(dep), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("drain_qa", 32'(qa), 32'(3 - k / 2));
      chk("drain_Ta", 32'(Ta), (k < 6) ? 32'h1 : 32'h0);
    end
    tick();
    chk("empty_dep", 32'(dep), 0);
    chk("empty_qa", 32'(qa), 0);
    La = RED;

    // 4: overflow on lane b, then balanced arrival/departure at full
    arr = 4'b0100;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        chk("full_qb", 32'(qb), 15);
        chk("full_ovf0", 32'(ovf), 0);
      end
    end
    chk("ovf_qb", 32'(qb), 15);
    chk("ovf_set", 32'(ovf), 1);
    Lb = GREEN;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("sat_dep", 32'(dep), (k % 2 == 0) ? 32'h4 : 32'h0);
      chk("sat_qb", 32'(qb), 15);
      chk("sat_ovf", 32'(ovf), 1);
    end
    arr     = 4'b0000;
    Lb      = RED;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst2_ovf", 32'(ovf), 0);
    chk("rst2_qb", 32'(qb), 0);

    // 5: LEFT drains only lane al; YELLOW mid-pace suppresses the departure
    arr = 4'b0011;
    repeat (2) tick();
    arr = 4'b0000;
    chk("l_qa_init", 32'(qa), 2);
    chk("l_qal_init", 32'(qal), 2);
    La = LEFT;
    tick();
    chk("l1_dep", 32'(dep), 0);
    tick();
    chk("l2_dep", 32'(dep), 32'h2);
    chk("l2_qal", 32'(qal), 1);
    tick();
    chk("l3_dep", 32'(dep), 0);
    La = YELLOW;
    tick();
    chk("y1_dep", 32'(dep), 0);
    chk("y1_qal", 32'(qal), 1);
    tick();
    chk("y2_dep", 32'(dep), 0);
    La = LEFT;
    tick();
    chk("l4_dep", 32'(dep), 0);
    chk("l4_qal", 32'(qal), 1);
    tick();
    chk("l5_dep", 32'(dep), 32'h2);
    chk("l5_qal", 32'(qal), 0);
    tick();
    chk("l6_dep", 32'(dep), 0);
    chk("l6_qal", 32'(qal), 0);
    chk("l6_qa", 32'(qa), 2);
    chk("l6_Tal", 32'(Tal), 0);

    // 6: one cycle of conflicting lights
    La = GREEN;
    Lb = LEFT;
    tick();
    La = RED;
    Lb = RED;
    repeat (3) tick();
    chk("conf_sticky", 32'(conflict_err), 32'(EXP_CONFLICT));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("conf_rst", 32'(conflict_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
